// File: rtl/tx_uart.sv
// UART transmitter: serializes one NB_BITS word as start, data (LSB first),
// optional parity and STOP_BITS stop bits, timed by a 16x oversampling tick.
// Latency: start bit on o_tx one clock after acceptance; frame length is
//   16 * (1 + NB_BITS + parity + STOP_BITS) counted i_rate ticks.
// Backpressure: o_busy high while a frame is in flight; i_tx_start is dropped
//   (not queued) while busy, and is accepted again in the o_tx_done cycle.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_rate      baud tick, one clock wide, 16 per bit period
//   i_tx_start  send request, sampled every clock
//   i_data      word to send, captured only on acceptance
//   o_tx        serial line, idle high (registered)
//   o_busy      frame in progress (registered)
//   o_tx_done   one-clock pulse at end of the last stop bit (registered)
module tx_uart #(
  parameter int NB_BITS   = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rate,
  input  logic               i_tx_start,
  input  logic [NB_BITS-1:0] i_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_tx_done
);

  // Values outside the legal sets fall back to no parity / one stop bit.
  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD  = (PARITY == 2);
  localparam bit TWO_STOP = (STOP_BITS == 2);
  localparam logic [3:0] LAST_BIT = 4'(NB_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           tick_cnt, tick_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic                 stop_cnt, stop_nxt;
  logic [NB_BITS-1:0]   shift_reg, shift_nxt;
  logic                 parity_bit, parity_nxt;
  logic                 tx_nxt;
  logic                 busy_nxt;
  logic                 done_nxt;
  logic                 tick_end;

  // Last tick of the current bit period.
  assign tick_end = i_rate && (tick_cnt == 4'd15);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 4'd0;
      stop_cnt   <= 1'b0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      o_tx_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_cnt    <= bit_nxt;
      stop_cnt   <= stop_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      o_tx       <= tx_nxt;
      o_busy     <= busy_nxt;
      o_tx_done  <= done_nxt;
    end
  end

  // o_tx is registered, so every branch drives the line value of the bit
  // that starts after this edge; transitions land on the edge after the
  // 16th tick of the previous bit.
  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_cnt;
    stop_nxt   = stop_cnt;
    shift_nxt  = shift_reg;
    parity_nxt = parity_bit;
    tx_nxt     = o_tx;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;

    // The 4-bit counter wraps 15 -> 0 by itself at the end of each bit.
    if ((state != S_IDLE) && i_rate) begin
      tick_nxt = tick_cnt + 4'd1;
    end

    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (i_tx_start && !o_busy) begin
          shift_nxt  = i_data;
          parity_nxt = PAR_ODD ? ~(^i_data) : ^i_data;
          // A tick arriving in the acceptance cycle is not counted.
          tick_nxt   = 4'd0;
          bit_nxt    = 4'd0;
          stop_nxt   = 1'b0;
          state_nxt  = S_START;
          tx_nxt     = 1'b0;
          busy_nxt   = 1'b1;
        end
      end

      S_START: begin
        if (tick_end) begin
          state_nxt = S_DATA;
          tx_nxt    = shift_reg[0];
        end
      end

      S_DATA: begin
        if (tick_end) begin
          shift_nxt = shift_reg >> 1;
          bit_nxt   = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) begin
            if (PAR_EN) begin
              state_nxt = S_PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            // Next data bit is the one about to shift into position 0.
            tx_nxt = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (tick_end) begin
          state_nxt = S_STOP;
          stop_nxt  = 1'b0;
          tx_nxt    = 1'b1;
        end
      end

      S_STOP: begin
        if (tick_end) begin
          if (TWO_STOP && !stop_cnt) begin
            stop_nxt = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            tx_nxt    = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
